// File: rtl/cpu_output_serializer.sv
// Buffers CPU output words in a FIFO and streams them MSB-byte-first over a byte valid/ready link.
// After halt it drains every buffered word, then raises a sticky done flag.
module cpu_output_serializer #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     halt,
   input  logic                     output_valid,
   input  logic [DATA_W-1:0]        output_data,
   output logic                     byte_valid,
   output logic [7:0]               byte_data,
   input  logic                     byte_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     done
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [DATA_W-1:0] shifter;
   logic [IW-1:0]     idx;
   logic              halt_seen;

   logic              not_empty_c;
   logic              last_c;
   logic              handshake_c;
   logic              pop_c;
   logic              capture_c;
   logic              push_c;
   logic              drop_c;
   logic [DATA_W-1:0] head_c;

   // FIFO pop/push decisions for this edge; a pop frees a slot for a same-edge push.
   always_comb begin
      not_empty_c = (count != '0);
      last_c      = (idx == IW'(BYTES - 1));
      handshake_c = byte_valid && byte_ready;
      head_c      = mem[rd_ptr];
      pop_c       = not_empty_c &&
                    ((state == IDLE) || ((state == SEND) && handshake_c && last_c));
      capture_c   = output_valid && !halt_seen && (state != DONE);
      push_c      = capture_c && ((count != CW'(DEPTH)) || pop_c);
      drop_c      = capture_c && !push_c;
   end

   assign byte_data = shifter[DATA_W-1 -: 8];

   // Word storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= output_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         shifter    <= '0;
         idx        <= '0;
         halt_seen  <= 1'b0;
         byte_valid <= 1'b0;
         overflow   <= 1'b0;
         done       <= 1'b0;
      end else begin
         if (halt) begin
            halt_seen <= 1'b1;
         end
         if (push_c) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (drop_c) begin
            overflow <= 1'b1;
         end
         if (push_c && !pop_c) begin
            count <= count + CW'(1);
         end else if (pop_c && !push_c) begin
            count <= count - CW'(1);
         end

         case (state)
            IDLE: begin
               if (not_empty_c) begin
                  shifter    <= head_c;
                  idx        <= '0;
                  byte_valid <= 1'b1;
                  state      <= SEND;
               end else if (halt_seen) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            SEND: begin
               if (handshake_c) begin
                  if (!last_c) begin
                     shifter <= shifter << 8;
                     idx     <= idx + IW'(1);
                  end else if (not_empty_c) begin
                     // Chain straight into the next word without an idle cycle.
                     shifter <= head_c;
                     idx     <= '0;
                  end else begin
                     byte_valid <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            DONE: begin
               byte_valid <= 1'b0;
               done       <= 1'b1;
            end
            default: begin
               byte_valid <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_output_serializer.sv
// Directed bench for cpu_output_serializer: a scoreboard queue of expected bytes
// is filled by the stimulus and drained by an independent handshake monitor.
module tb_cpu_output_serializer;

   logic        clk;
   logic        reset;
   logic        halt;
   logic        output_valid;
   logic [63:0] output_data;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic [3:0]  count;
   logic        overflow;
   logic        done;

   int          n_checks;
   int          n_fail;
   int          hs_count;
   int          hs0;
   logic [7:0]  exp_q [$];
   logic        holding;
   logic [7:0]  held;

   cpu_output_serializer #(.DATA_W(64), .DEPTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .halt         (halt),
      .output_valid (output_valid),
      .output_data  (output_data),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .count        (count),
      .overflow     (overflow),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input logic [63:0] w);
      for (int b = 7; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (k < 300 && !(byte_valid == 1'b0 && count == 4'd0)) begin
         @(negedge clk);
         k++;
      end
      check({name, "_drain_timeout"}, 64'(k >= 300), 64'd0);
   endtask

   function automatic logic [63:0] t3_word(input int i);
      logic [63:0] w;
      w = {4{8'(i), 8'(8'hF0 - i)}};
      return w;
   endfunction

   // Monitor: every accepted byte is compared with the scoreboard head; stalled bytes must hold.
   always @(negedge clk) begin
      if (byte_valid && holding) begin
         check("hold_stable", 64'(byte_data), 64'(held));
      end
      if (byte_valid && byte_ready) begin
         hs_count++;
         holding = 1'b0;
         if (exp_q.size() == 0) begin
            check("unexpected_byte", 64'(byte_data), 64'hDEAD);
         end else begin
            check("byte", 64'(byte_data), 64'(exp_q.pop_front()));
         end
      end else if (byte_valid) begin
         holding = 1'b1;
         held    = byte_data;
      end else begin
         holding = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      hs_count     = 0;
      holding      = 1'b0;
      held         = '0;
      reset        = 1'b1;
      halt         = 1'b0;
      output_valid = 1'b0;
      output_data  = '0;
      byte_ready   = 1'b0;
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_byte_valid", 64'(byte_valid), 64'd0);
      check("rst_byte_data", 64'(byte_data), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_done", 64'(done), 64'd0);

      // Single word, always ready
      step();
      output_valid = 1'b1;
      output_data  = 64'h0123456789ABCDEF;
      byte_ready   = 1'b1;
      expect_word(64'h0123456789ABCDEF);
      step();
      output_valid = 1'b0;
      @(negedge clk);
      check("t1_latency_valid", 64'(byte_valid), 64'd0);
      check("t1_count_one", 64'(count), 64'd1);
      step();
      hs0 = hs_count;
      @(negedge clk);
      check("t1_valid_up", 64'(byte_valid), 64'd1);
      check("t1_first_byte", 64'(byte_data), 64'h01);
      repeat (8) step();
      check("t1_handshakes", 64'(hs_count - hs0), 64'd8);
      check("t1_valid_down", 64'(byte_valid), 64'd0);

      // Same word with toggling ready
      step();
      output_valid = 1'b1;
      output_data  = 64'h0123456789ABCDEF;
      byte_ready   = 1'b0;
      expect_word(64'h0123456789ABCDEF);
      step();
      output_valid = 1'b0;
      step();
      hs0 = hs_count;
      for (int i = 0; i < 16; i++) begin
         byte_ready = (i % 2 == 0);
         step();
      end
      check("t2_handshakes", 64'(hs_count - hs0), 64'd8);
      check("t2_valid_down", 64'(byte_valid), 64'd0);

      // Overflow with a stalled sink
      byte_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         output_valid = 1'b1;
         output_data  = t3_word(i);
         if (i < 9) expect_word(t3_word(i));
      end
      step();
      output_valid = 1'b0;
      @(negedge clk);
      check("t3_count_full", 64'(count), 64'd8);
      check("t3_overflow", 64'(overflow), 64'd1);
      check("t3_valid_held", 64'(byte_valid), 64'd1);
      check("t3_head_byte", 64'(byte_data), 64'h00);
      step();
      byte_ready = 1'b1;
      drain("t3");
      check("t3_overflow_sticky", 64'(overflow), 64'd1);
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // Back-to-back words, no bubble
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.delete();
      step();
      output_valid = 1'b1;
      output_data  = 64'hA0A1A2A3A4A5A6A7;
      expect_word(64'hA0A1A2A3A4A5A6A7);
      step();
      output_data  = 64'hB0B1B2B3B4B5B6B7;
      expect_word(64'hB0B1B2B3B4B5B6B7);
      step();
      output_valid = 1'b0;
      hs0 = hs_count;
      repeat (16) step();
      check("t4_contiguous", 64'(hs_count - hs0), 64'd16);
      check("t4_valid_down", 64'(byte_valid), 64'd0);

      // Halt on the same edge as the last word; later words ignored
      step();
      output_valid = 1'b1;
      output_data  = 64'h1357924680ACE0FF;
      halt         = 1'b1;
      expect_word(64'h1357924680ACE0FF);
      step();
      halt        = 1'b0;
      output_data = 64'hDEADBEEFDEADBEEF;
      step();
      output_valid = 1'b0;
      repeat (8) step();
      check("t5_done_not_yet", 64'(done), 64'd0);
      check("t5_valid_down", 64'(byte_valid), 64'd0);
      step();
      check("t5_done_set", 64'(done), 64'd1);
      output_valid = 1'b1;
      output_data  = 64'h0F0F0F0F0F0F0F0F;
      repeat (3) step();
      output_valid = 1'b0;
      @(negedge clk);
      check("t5_done_sticky", 64'(done), 64'd1);
      check("t5_no_more_bytes", 64'(byte_valid), 64'd0);
      check("t5_count_zero", 64'(count), 64'd0);
      check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a word
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.delete();
      byte_ready = 1'b1;
      step();
      output_valid = 1'b1;
      output_data  = 64'h1122334455667788;
      expect_word(64'h1122334455667788);
      step();
      output_valid = 1'b0;
      hs0 = hs_count;
      repeat (4) step();
      check("t6_three_bytes", 64'(hs_count - hs0), 64'd3);
      reset      = 1'b1;
      byte_ready = 1'b0;
      exp_q.delete();
      step();
      reset = 1'b0;
      @(negedge clk);
      check("t6_valid", 64'(byte_valid), 64'd0);
      check("t6_count", 64'(count), 64'd0);
      check("t6_overflow", 64'(overflow), 64'd0);
      check("t6_done", 64'(done), 64'd0);
      step();
      byte_ready   = 1'b1;
      output_valid = 1'b1;
      output_data  = 64'hFFEEDDCCBBAA9988;
      expect_word(64'hFFEEDDCCBBAA9988);
      step();
      output_valid = 1'b0;
      step();
      @(negedge clk);
      check("t6_new_valid", 64'(byte_valid), 64'd1);
      check("t6_new_first", 64'(byte_data), 64'hFF);
      drain("t6");
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
